// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and sample type for the rotator, gain compensation
// and the NCO front end.
package cordic_pkg;

  localparam int CORDIC_WIDTH = 16;

  // CORDIC gain inverse K = 0.607253 in Q1.15
  localparam logic signed [15:0] CORDIC_K_Q15 = 16'sd19898;
  localparam int                 CORDIC_FRAC  = 15;
  localparam int                 CORDIC_RND   = 1 << 14;

  typedef logic signed [CORDIC_WIDTH-1:0] cordic_sample_t;

endpackage

// File: rtl/cordic_out_fifo.sv
// Synchronous FIFO with a registered head entry (not fall-through).
// level counts entries held in memory plus the head register.
module cordic_out_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] head_q;
  logic          head_vld_q;
  logic          pop_en, wr_en, load;

  assign level  = cnt_q + LW'(head_vld_q);
  assign full   = (level == LW'(DEPTH));
  assign empty  = ~head_vld_q;
  assign rdata  = head_q;
  assign pop_en = head_vld_q & pop;
  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign wr_en  = push & (~full | pop_en);
  // Refill the head register whenever it is empty or being consumed
  assign load   = (cnt_q != '0) & (~head_vld_q | pop_en);

  // Memory occupancy next state
  always_comb begin
    cnt_d = cnt_q + LW'(wr_en) - LW'(load);
  end

  // Pointers, occupancy and head register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (load)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
      if (load) begin
        head_q     <= mem[rptr_q];
        head_vld_q <= 1'b1;
      end else if (pop_en) begin
        head_vld_q <= 1'b0;
      end
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/cordic_gain_comp.sv
// CORDIC gain compensation: regenerates sample validity behind the rotator,
// scales x/y by K in Q1.15 and buffers results in a ready/valid FIFO.
// Build option: define CORDIC_GAIN_ROUND_EN for round-half-up, otherwise the
// scaled result is truncated (floor). Latency is identical in both builds.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     samp_valid,
  input  logic signed [WIDTH-1:0]  cx_in,
  input  logic signed [WIDTH-1:0]  cy_in,
  input  logic                     out_ready,
  input  logic                     ovf_clr,
  output logic                     out_valid,
  output logic signed [WIDTH-1:0]  x_out,
  output logic signed [WIDTH-1:0]  y_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] K_EXT = PW'(CORDIC_K_Q15);
`ifdef CORDIC_GAIN_ROUND_EN
  localparam logic signed [PW-1:0] RND_EXT = PW'(CORDIC_RND);
`endif

  logic [STAGES-1:0]       dly_q;
  logic signed [PW-1:0]    px_q, py_q;
  logic                    v1_q;
  logic signed [PW-1:0]    px_adj, py_adj;
  logic signed [WIDTH-1:0] rx_d, ry_d, rx_q, ry_q;
  logic                    v2_q;
  logic                    ovf_q, ovf_d;
  logic                    full, empty, drop;
  logic [PW-1:0]           head;

  // Valid delay line matched to rotator latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dly_q <= '0;
    else     dly_q <= {dly_q[STAGES-2:0], samp_valid};
  end

  // Multiply stage: products only captured for valid rotator outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_q <= '0;
      py_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= dly_q[STAGES-1];
      if (dly_q[STAGES-1]) begin
        px_q <= PW'(cx_in) * K_EXT;
        py_q <= PW'(cy_in) * K_EXT;
      end
    end
  end

  // Round/truncate back to sample width; |K| < 1 so no saturation is needed
  always_comb begin
`ifdef CORDIC_GAIN_ROUND_EN
    px_adj = px_q + RND_EXT;
    py_adj = py_q + RND_EXT;
`else
    px_adj = px_q;
    py_adj = py_q;
`endif
    rx_d = WIDTH'(px_adj >>> CORDIC_FRAC);
    ry_d = WIDTH'(py_adj >>> CORDIC_FRAC);
  end

  // Round stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q <= '0;
      ry_q <= '0;
      v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        rx_q <= rx_d;
        ry_q <= ry_d;
      end
    end
  end

  cordic_out_fifo #(
    .DW    (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (v2_q),
    .wdata ({rx_q, ry_q}),
    .pop   (out_ready),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign out_valid = ~empty;
  assign x_out     = head[PW-1:WIDTH];
  assign y_out     = head[WIDTH-1:0];
  assign drop      = v2_q & full & ~(out_valid & out_ready);
  assign overflow  = ovf_q;

  // Sticky overflow next state: a drop beats a simultaneous clear
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Sticky overflow register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Self-checking bench for cordic_gain_comp: directed vectors, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_cordic_gain_comp;
  import cordic_pkg::*;

  localparam int WIDTH  = 16;
  localparam int STAGES = 16;
  localparam int DEPTH  = 8;
  localparam int LAT    = STAGES + 3;
  localparam int RING   = 64;

`ifdef CORDIC_GAIN_ROUND_EN
  localparam int E1X   = 1;
  localparam int E100X = 61;
`else
  localparam int E1X   = 0;
  localparam int E100X = 60;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   samp_valid = 1'b0;
  logic                   out_ready = 1'b0;
  logic                   ovf_clr = 1'b0;
  cordic_sample_t         cx_in = '0;
  cordic_sample_t         cy_in = '0;
  logic                   out_valid;
  cordic_sample_t         x_out, y_out;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   overflow;

  cordic_gain_comp #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .samp_valid (samp_valid),
    .cx_in      (cx_in),
    .cy_in      (cy_in),
    .out_ready  (out_ready),
    .ovf_clr    (ovf_clr),
    .out_valid  (out_valid),
    .x_out      (x_out),
    .y_out      (y_out),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: samples enter a bounded queue at their arrival cycle and
  // become visible at the head one cycle after arriving.
  typedef struct {int x; int y; int w;} ent_t;
  ent_t q[$];
  bit   rv[RING];
  int   rx[RING], ry[RING];
  bit   mw[RING];
  int   mx[RING], my[RING];
  bit   movf, mval;
  int   mlast_x, mlast_y;

  typedef struct {int cx; int cy; int ex; int ey;} vec_t;
  vec_t vt[5];

  function automatic int comp(input int v);
    longint p, r;
    p = longint'(v) * 19898;
`ifdef CORDIC_GAIN_ROUND_EN
    p = p + 16384;
`endif
    r = p / 32768;
    if ((p % 32768 != 0) && (p < 0)) r = r - 1;
    return int'(r);
  endfunction

  function automatic int rnd16();
    logic signed [15:0] t;
    t = 16'($urandom);
    return int'(t);
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < RING; i++) begin
      rv[i] = 1'b0;
      mw[i] = 1'b0;
    end
    movf    = 1'b0;
    mval    = 1'b0;
    mlast_x = 0;
    mlast_y = 0;
  endtask

  // One clock: drive inputs, advance the model on the edge, then check outputs
  task automatic step(input bit s, input int sx, input int sy);
    int   rs, ws, slot;
    bit   drop;
    ent_t e;
    samp_valid = s;
    if (s) begin
      rs = (cyc + STAGES) % RING;
      rv[rs] = 1'b1; rx[rs] = sx; ry[rs] = sy;
      ws = (cyc + STAGES + 2) % RING;
      mw[ws] = 1'b1; mx[ws] = comp(sx); my[ws] = comp(sy);
    end
    slot = cyc % RING;
    if (rv[slot]) begin
      cx_in = WIDTH'(rx[slot]);
      cy_in = WIDTH'(ry[slot]);
      rv[slot] = 1'b0;
    end else begin
      cx_in = WIDTH'($urandom);
      cy_in = WIDTH'($urandom);
    end
    @(posedge clk);
    drop = 1'b0;
    if (mval && out_ready) q.delete(0);
    if (mw[slot]) begin
      mw[slot] = 1'b0;
      if (q.size() < DEPTH) begin
        e.x = mx[slot]; e.y = my[slot]; e.w = cyc;
        q.push_back(e);
      end else begin
        drop = 1'b1;
      end
    end
    if (drop)         movf = 1'b1;
    else if (ovf_clr) movf = 1'b0;
    mval = (q.size() > 0) && (q[0].w < cyc);
    if (mval) begin
      mlast_x = q[0].x;
      mlast_y = q[0].y;
    end
    cyc++;
    #1;
    chk("out_valid", out_valid, mval);
    chk("x_out", x_out, mlast_x);
    chk("y_out", y_out, mlast_y);
    chk("fifo_level", fifo_level, q.size());
    chk("overflow", overflow, movf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0);
  endtask

  // Asynchronous reset asserted between edges
  task automatic reset_now();
    #2 rst = 1'b1;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst x_out", x_out, 0);
    chk("rst y_out", y_out, 0);
    chk("rst fifo_level", fifo_level, 0);
    chk("rst overflow", overflow, 0);
    model_clear();
    samp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      cyc++;
    end
    #3 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, n;
    int bpx[10], bpy[10];
    int sq[$];

    vt[0] = '{1, -1, E1X, -1};
    vt[1] = '{-32768, 32767, -19898, 19897};
    vt[2] = '{100, -100, E100X, -61};
    vt[3] = '{0, 2, 0, 1};
    vt[4] = '{16384, -16384, 9949, -9949};

    model_clear();
    #1;
    reset_now();

    // Single-sample vectors: exact latency and value
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, vt[i].cx, vt[i].cy);
      lat = 0;
      while (!out_valid && lat < 40) begin
        step(1'b0, 0, 0);
        lat++;
      end
      chk("vec latency", lat, LAT);
      chk("vec x", x_out, vt[i].ex);
      chk("vec y", y_out, vt[i].ey);
      step(1'b0, 0, 0);
      chk("vec popped", out_valid, 0);
    end

    // Backpressure: 10 samples into a stalled 8-deep FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bpx[i] = rnd16();
      bpy[i] = rnd16();
      step(1'b1, bpx[i], bpy[i]);
    end
    idle(LAT + 2);
    chk("bp level", fifo_level, DEPTH);
    chk("bp overflow", overflow, 1);
    out_ready = 1'b1;
    n = 0;
    for (int t = 0; t < 20; t++) begin
      if (out_valid) begin
        if (n < 10) begin
          chk("bp order x", x_out, comp(bpx[n]));
          chk("bp order y", y_out, comp(bpy[n]));
        end
        n++;
      end
      step(1'b0, 0, 0);
    end
    chk("bp count", n, DEPTH);
    chk("bp overflow held", overflow, 1);
    ovf_clr = 1'b1;
    step(1'b0, 0, 0);
    ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Full FIFO with push and pop in the same cycle
    out_ready = 1'b0;
    for (int t = 0; t < 48; t++) begin
      if (t == 26) out_ready = 1'b1;
      if (t < 30) step(1'b1, rnd16(), rnd16());
      else        step(1'b0, 0, 0);
      if (t >= 26) begin
        chk("full level", fifo_level, DEPTH);
        chk("full no drop", overflow, 0);
      end
    end
    idle(DEPTH + 4);
    chk("full drained", fifo_level, 0);

    // Reset with 3 samples buffered and 5 in the delay line
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) step(1'b1, rnd16(), rnd16());
    idle(18);
    chk("pre-rst level", fifo_level, 3);
    for (int t = 0; t < 5; t++) step(1'b1, rnd16(), rnd16());
    reset_now();
    out_ready = 1'b1;
    for (int t = 0; t < LAT + 5; t++) begin
      step(1'b0, 0, 0);
      chk("post-rst quiet", out_valid, 0);
    end

    // Sparse strobes, garbage on cx/cy in between
    for (int t = 0; t < 60; t++) begin
      if (t % 3 == 0 && t < 40) begin
        sq.push_back(cyc);
        step(1'b1, rnd16(), rnd16());
      end else begin
        step(1'b0, 0, 0);
      end
      if (out_valid) begin
        if (sq.size() > 0) begin
          chk("sparse latency", (cyc - 1) - sq[0], LAT);
          sq.delete(0);
        end else begin
          chk("sparse spurious", out_valid, 0);
        end
      end
    end
    chk("sparse all seen", sq.size(), 0);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      step(($urandom_range(0, 9) < 6), rnd16(), rnd16());
    end
    ovf_clr   = 1'b0;
    out_ready = 1'b1;
    idle(LAT + DEPTH + 5);
    chk("final empty", fifo_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
